// File: rtl/pe_seq_ctrl.sv
// Job sequencer for one MAC PE: streams paired W/I operands, seeds each output, collects results.
// Optional build macro PE_SEQ_CTRL_TIMEOUT_EN adds the DRAIN watchdog and the err output.
module pe_seq_ctrl #(
  parameter int DataInWidth  = 8,
  parameter int DataOutWidth = 16,
  parameter int IndexSize    = 4,
  parameter int TimeoutWidth = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_rdy,
  input  logic [IndexSize-1:0]    cmd_len,
  input  logic [IndexSize-1:0]    cmd_cnt,
  input  logic [DataInWidth-1:0]  cmd_bias,
  input  logic                    w_valid,
  output logic                    w_rdy,
  input  logic [DataInWidth-1:0]  w_data,
  input  logic                    i_valid,
  output logic                    i_rdy,
  input  logic [DataInWidth-1:0]  i_data,
  output logic                    pe_w_valid,
  input  logic                    pe_w_rdy,
  output logic [DataInWidth-1:0]  pe_w_data,
  output logic                    pe_i_valid,
  input  logic                    pe_i_rdy,
  output logic [DataInWidth-1:0]  pe_i_data,
  output logic                    pe_o_nop_in,
  output logic [DataInWidth-1:0]  pe_o_data_in,
  input  logic                    pe_o_nop_out,
  input  logic [DataOutWidth-1:0] pe_o_data,
  output logic                    pe_o_rdy,
  output logic                    res_valid,
  input  logic                    res_rdy,
  output logic [DataOutWidth-1:0] res_data,
  output logic                    res_last,
  output logic                    busy,
`ifdef PE_SEQ_CTRL_TIMEOUT_EN
  output logic                    err,
`endif
  output logic                    done
);

  // state | meaning
  // IDLE  | waiting for a job command
  // FEED  | streaming operand beats for the current output
  // DRAIN | waiting for the PE to return the finished result
  // OUT   | presenting the result downstream
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} state_e;

  state_e                  state_q, state_d;
  logic [IndexSize-1:0]    len_q, len_d, cnt_q, cnt_d;
  logic [IndexSize-1:0]    beat_cnt_q, beat_cnt_d, out_cnt_q, out_cnt_d;
  logic [DataInWidth-1:0]  bias_q, bias_d;
  logic [DataOutWidth-1:0] res_data_q, res_data_d;

  logic in_feed, beat, seed, last_out, timeout;

  assign in_feed  = (state_q == FEED);
  assign beat     = in_feed & w_valid & i_valid & pe_w_rdy & pe_i_rdy;
  assign seed     = beat & (beat_cnt_q == '0);
  assign last_out = (out_cnt_q == cnt_q);

`ifdef PE_SEQ_CTRL_TIMEOUT_EN
  logic [TimeoutWidth-1:0] wdog_q, wdog_d;

  // Runs only while in DRAIN, so it is always zero on entry.
  always_comb wdog_d = (state_q == DRAIN) ? wdog_q + 1'b1 : '0;

  assign timeout = (state_q == DRAIN) & pe_o_nop_out & (wdog_q == '1);
  assign err     = timeout & ~reset;
`else
  localparam int unused_timeout_w = TimeoutWidth;
  assign timeout = 1'b0;
`endif

  // Joint handshake: neither side transfers unless all four parties are ready.
  assign w_rdy        = in_feed & i_valid & pe_w_rdy & pe_i_rdy;
  assign i_rdy        = in_feed & w_valid & pe_w_rdy & pe_i_rdy;
  assign pe_w_valid   = in_feed & w_valid & i_valid & pe_i_rdy;
  assign pe_i_valid   = in_feed & w_valid & i_valid & pe_w_rdy;
  assign pe_w_data    = in_feed ? w_data : '0;
  assign pe_i_data    = in_feed ? i_data : '0;
  assign pe_o_nop_in  = ~seed;
  assign pe_o_data_in = seed ? bias_q : '0;
  assign pe_o_rdy     = (state_q == DRAIN);
  assign res_valid    = (state_q == OUT);
  assign res_last     = (state_q == OUT) & last_out;
  assign res_data     = res_data_q;
  assign busy         = (state_q != IDLE);
  assign cmd_rdy      = (state_q == IDLE) & ~reset;
  assign done         = (state_q == OUT) & res_rdy & last_out & ~reset;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    bias_d     = bias_q;
    beat_cnt_d = beat_cnt_q;
    out_cnt_d  = out_cnt_q;
    res_data_d = res_data_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          len_d      = cmd_len;
          cnt_d      = cmd_cnt;
          bias_d     = cmd_bias;
          beat_cnt_d = '0;
          out_cnt_d  = '0;
          state_d    = FEED;
        end
      end
      FEED: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pe_o_nop_out) begin
          res_data_d = pe_o_data;
          state_d    = OUT;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      OUT: begin
        if (res_rdy) begin
          if (last_out) begin
            state_d = IDLE;
          end else begin
            out_cnt_d  = out_cnt_q + 1'b1;
            beat_cnt_d = '0;
            state_d    = FEED;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      bias_q     <= '0;
      beat_cnt_q <= '0;
      out_cnt_q  <= '0;
      res_data_q <= '0;
`ifdef PE_SEQ_CTRL_TIMEOUT_EN
      wdog_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      bias_q     <= bias_d;
      beat_cnt_q <= beat_cnt_d;
      out_cnt_q  <= out_cnt_d;
      res_data_q <= res_data_d;
`ifdef PE_SEQ_CTRL_TIMEOUT_EN
      wdog_q     <= wdog_d;
`endif
    end
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Self-checking bench for pe_seq_ctrl: directed jobs, a PE stub, and a per-cycle job-level model.
// With PE_SEQ_CTRL_TIMEOUT_EN defined the DUT is built with TimeoutWidth=4 and the watchdog is exercised.
module tb_pe_seq_ctrl;
  localparam int DW = 8;
  localparam int OW = 16;
  localparam int IS = 4;
`ifdef PE_SEQ_CTRL_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 8;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_rdy;
  logic [IS-1:0] cmd_len, cmd_cnt;
  logic [DW-1:0] cmd_bias;
  logic          w_valid, w_rdy, i_valid, i_rdy;
  logic [DW-1:0] w_data, i_data;
  logic          pe_w_valid, pe_w_rdy, pe_i_valid, pe_i_rdy;
  logic [DW-1:0] pe_w_data, pe_i_data;
  logic          pe_o_nop_in;
  logic [DW-1:0] pe_o_data_in;
  logic          pe_o_nop_out;
  logic [OW-1:0] pe_o_data;
  logic          pe_o_rdy;
  logic          res_valid, res_rdy, res_last;
  logic [OW-1:0] res_data;
  logic          busy, done;
`ifdef PE_SEQ_CTRL_TIMEOUT_EN
  logic          err;
`endif

  pe_seq_ctrl #(.DataInWidth(DW), .DataOutWidth(OW), .IndexSize(IS), .TimeoutWidth(TW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_rdy(cmd_rdy), .cmd_len(cmd_len), .cmd_cnt(cmd_cnt), .cmd_bias(cmd_bias),
    .w_valid(w_valid), .w_rdy(w_rdy), .w_data(w_data),
    .i_valid(i_valid), .i_rdy(i_rdy), .i_data(i_data),
    .pe_w_valid(pe_w_valid), .pe_w_rdy(pe_w_rdy), .pe_w_data(pe_w_data),
    .pe_i_valid(pe_i_valid), .pe_i_rdy(pe_i_rdy), .pe_i_data(pe_i_data),
    .pe_o_nop_in(pe_o_nop_in), .pe_o_data_in(pe_o_data_in),
    .pe_o_nop_out(pe_o_nop_out), .pe_o_data(pe_o_data), .pe_o_rdy(pe_o_rdy),
    .res_valid(res_valid), .res_rdy(res_rdy), .res_data(res_data), .res_last(res_last),
    .busy(busy),
`ifdef PE_SEQ_CTRL_TIMEOUT_EN
    .err(err),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // PE stub: multiply-accumulate, answering after pe_delay DRAIN cycles when enabled.
  logic          pe_en = 1'b1;
  int            pe_delay = 0;
  int            drain_run = 0;
  logic [OW-1:0] acc = '0;

  always @(posedge clk) begin
    drain_run <= pe_o_rdy ? drain_run + 1 : 0;
    if (pe_w_valid && pe_w_rdy)
      acc <= (pe_o_nop_in ? acc : OW'(pe_o_data_in)) + OW'(pe_w_data) * OW'(pe_i_data);
  end
  assign pe_o_nop_out = !(pe_o_rdy && pe_en && drain_run >= pe_delay);
  assign pe_o_data    = pe_o_nop_out ? 16'hBEEF : acc;

  // Job-level model.
  logic [OW-1:0] exp_q[$];
  logic          mbusy = 0, mfeed = 0, mdrain = 0, mout = 0;
  int            m_beat = 0, m_out = 0, cur_len = 0, cur_cnt = 0, cur_bias = 0;
  int            done_count = 0, beat_total = 0, seed_total = 0, err_count = 0;
  logic [OW-1:0] last_res = '0, prev_pe_data = '0, prev_res_data = '0, expv;
  logic          prev_pe_res = 0, prev_hold = 0;
  logic          bw, bi, bpw, bpi, all_rdy, exp_err;

  always @(negedge clk) begin
    if (reset) begin
      chk("cmd_rdy_in_reset", cmd_rdy, 1'b0);
      mbusy = 0; mfeed = 0; mdrain = 0; mout = 0;
      m_beat = 0; m_out = 0; prev_pe_res = 0; prev_hold = 0;
    end else begin
      bw  = w_valid && w_rdy;
      bi  = i_valid && i_rdy;
      bpw = pe_w_valid && pe_w_rdy;
      bpi = pe_i_valid && pe_i_rdy;
      all_rdy = w_valid && i_valid && pe_w_rdy && pe_i_rdy;
      chk("busy", busy, mbusy);
      chk("cmd_rdy", cmd_rdy, !mbusy);
      chk("joint_hs", {bi, bpw, bpi}, {3{bw}});
      chk("beat_fire", bpw, mfeed && all_rdy);
      chk("pe_o_rdy", pe_o_rdy, mdrain);
      chk("res_valid", res_valid, mout);
      chk("seed_nop", pe_o_nop_in, !(bpw && m_beat == 0));
      if (bpw && m_beat == 0) chk("seed_val", pe_o_data_in, cur_bias);
      if (bpw) begin
        chk("w_pass", pe_w_data, w_data);
        chk("i_pass", pe_i_data, i_data);
      end
      if (prev_pe_res) chk("res_capture", res_data, prev_pe_data);
      if (prev_hold) chk("res_hold_data", res_data, prev_res_data);
      if (res_valid) chk("res_last", res_last, m_out == cur_cnt);
      if (res_valid && res_rdy) begin
        if (exp_q.size() == 0) chk("res_unexpected", 1'b1, 1'b0);
        else begin
          expv = exp_q.pop_front();
          chk("res_data", res_data, expv);
        end
        chk("beats_per_out", m_beat, cur_len + 1);
        chk("done", done, m_out == cur_cnt);
      end else begin
        chk("done_quiet", done, 1'b0);
      end
`ifdef PE_SEQ_CTRL_TIMEOUT_EN
      exp_err = mdrain && pe_o_nop_out && drain_run == (2**TW - 1);
      chk("err", err, exp_err);
      if (exp_err) begin
        err_count++;
        mdrain = 0; mbusy = 0;
      end
`endif
      // Model updates from what happened in this cycle.
      if (bpw) begin
        if (!pe_o_nop_in) seed_total++;
        m_beat++; beat_total++;
        if (m_beat == cur_len + 1) begin mfeed = 0; mdrain = 1; end
      end
      if (pe_o_rdy && !pe_o_nop_out) begin mdrain = 0; mout = 1; end
      prev_pe_res  = pe_o_rdy && !pe_o_nop_out;
      prev_pe_data = pe_o_data;
      prev_hold     = res_valid && !res_rdy;
      prev_res_data = res_data;
      if (res_valid && res_rdy) begin
        mout = 0; m_beat = 0; last_res = res_data;
        if (m_out == cur_cnt) begin mbusy = 0; done_count++; end
        else begin m_out++; mfeed = 1; end
      end
      if (cmd_valid && cmd_rdy) begin
        mbusy = 1; mfeed = 1; m_beat = 0; m_out = 0;
        cur_len = int'(cmd_len); cur_cnt = int'(cmd_cnt); cur_bias = int'(cmd_bias);
      end
    end
  end

  task automatic idle_inputs();
    cmd_valid = 0; w_valid = 0; i_valid = 0; res_rdy = 0;
    pe_w_rdy = 1; pe_i_rdy = 1;
  endtask

  // Runs one job; w(beat)=wb+ws*beat, i(output)=ib+is_*output. abort_after>=0 resets after that many beats.
  task automatic run_job(input int len, input int cnt, input int bias, input int wb, input int ws,
                         input int ib, input int is_, input bit w_toggle, input int stall_start,
                         input int stall_len, input int res_stall, input int pe_dly,
                         input bit busy_cmd, input int abort_after);
    int total, fired, cyc, rv_seen, ob, bb;
    bit accepted, done_seen, aborted;
    logic [OW-1:0] e;
    total = (len + 1) * (cnt + 1);
    if (abort_after < 0)
      for (int o = 0; o <= cnt; o++) begin
        e = OW'(bias);
        for (int b = 0; b <= len; b++) e = e + OW'(DW'(wb + ws * b)) * OW'(DW'(ib + is_ * o));
        exp_q.push_back(e);
      end
    pe_delay = pe_dly;
    fired = 0; cyc = 0; rv_seen = 0; accepted = 0; done_seen = 0; aborted = 0;
    while (!done_seen && !aborted && cyc < 600) begin
      @(posedge clk); #1;
      cmd_valid = !accepted || busy_cmd;
      cmd_len   = accepted ? IS'(1) : IS'(len);
      cmd_cnt   = accepted ? IS'(0) : IS'(cnt);
      cmd_bias  = accepted ? DW'(99) : DW'(bias);
      ob = fired / (len + 1);
      bb = fired % (len + 1);
      w_data  = DW'(wb + ws * bb);
      i_data  = DW'(ib + is_ * ob);
      i_valid = fired < total;
      w_valid = (fired < total) && (!w_toggle || (cyc % 2 == 0));
      pe_i_rdy = !(cyc >= stall_start && cyc < stall_start + stall_len);
      res_rdy  = rv_seen >= res_stall;
      @(negedge clk);
      if (cmd_valid && cmd_rdy) accepted = 1;
      if (w_valid && w_rdy) fired++;
      if (res_valid) rv_seen = res_rdy ? 0 : rv_seen + 1;
      if (done) done_seen = 1;
      if (abort_after >= 0 && fired == abort_after) aborted = 1;
      cyc++;
    end
    @(posedge clk); #1;
    idle_inputs();
    if (aborted) begin
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      exp_q.delete();
    end else if (!done_seen) begin
      chk("job_timeout", 1'b0, 1'b1);
    end
  endtask

  initial begin
    reset = 1;
    cmd_len = '0; cmd_cnt = '0; cmd_bias = '0; w_data = '0; i_data = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_cmd_rdy", cmd_rdy, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valids", {w_rdy, i_rdy, pe_w_valid, pe_i_valid, pe_o_rdy, res_valid, res_last}, 7'b0);
    chk("rst_nop_in", pe_o_nop_in, 1'b1);
    chk("rst_data", {pe_o_data_in, res_data, pe_w_data, pe_i_data}, 40'b0);
    chk("rst_done", done, 1'b0);

    // Single job: bias 4 + 3*(2*3) = 22.
    run_job(2, 0, 4, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, -1);
    chk("t1_done", done_count, 1);
    chk("t1_beats", beat_total, 3);
    chk("t1_seeds", seed_total, 1);
    chk("t1_res", last_res, 22);

    // Three single-beat outputs: 7+5*1, 7+5*2, 7+5*3.
    run_job(0, 2, 7, 5, 0, 1, 1, 0, 0, 0, 0, 1, 0, -1);
    chk("t2_done", done_count, 2);
    chk("t2_beats", beat_total, 6);
    chk("t2_seeds", seed_total, 4);
    chk("t2_res", last_res, 22);

    // Backpressure: toggling w_valid, pe_i_rdy low 3 cycles, res_rdy low 5 cycles, slow PE.
    // Outputs: 1+2*(1+2+3+4)=21, 1+3*10=31.
    run_job(3, 1, 1, 1, 1, 2, 1, 1, 2, 3, 5, 2, 0, -1);
    chk("t3_done", done_count, 3);
    chk("t3_beats", beat_total, 14);
    chk("t3_res", last_res, 31);

    // Maximum length with cmd_valid held during the job: sum 1..16 = 136.
    run_job(15, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, -1);
    chk("t4_done", done_count, 4);
    chk("t4_beats", beat_total, 30);
    chk("t4_res", last_res, 136);

    // Reset after two beats of a job.
    run_job(5, 0, 9, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2);
    @(negedge clk);
    chk("t5_busy", busy, 1'b0);
    chk("t5_nop_in", pe_o_nop_in, 1'b1);
    chk("t5_cmd_rdy", cmd_rdy, 1'b1);
    chk("t5_no_done", done_count, 4);

    // Clean job after the reset: 3 + 2*(4*5) = 43.
    run_job(1, 0, 3, 4, 0, 5, 0, 0, 0, 0, 0, 0, 0, -1);
    chk("t6_done", done_count, 5);
    chk("t6_res", last_res, 43);

`ifdef PE_SEQ_CTRL_TIMEOUT_EN
    begin
      int cyc;
      pe_en = 0;
      @(posedge clk); #1;
      cmd_valid = 1; cmd_len = '0; cmd_cnt = '0; cmd_bias = 8'd1;
      w_valid = 1; i_valid = 1; w_data = 8'd1; i_data = 8'd1;
      cyc = 0;
      while (err_count == 0 && cyc < 60) begin
        @(negedge clk);
        if (cmd_valid && cmd_rdy) begin @(posedge clk); #1 cmd_valid = 0; end
        else if (w_valid && w_rdy) begin @(posedge clk); #1 w_valid = 0; i_valid = 0; end
        else @(posedge clk);
        cyc++;
      end
      @(negedge clk);
      chk("t7_err_once", err_count, 1);
      chk("t7_cmd_rdy", cmd_rdy, 1'b1);
      chk("t7_no_done", done_count, 5);
      idle_inputs();
      pe_en = 1;
    end
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
